// File: rtl/regfile_writeback_if.sv
// rtl/regfile_writeback_if.sv - result handshakes, register write port and forwarding bundle
interface regfile_writeback_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
);
    localparam int CW = $clog2(DEPTH + 1);

    logic                   ld_valid;
    logic                   ld_ready;
    logic [ADDR_W-1:0]      ld_dest;
    logic [DATA_W-1:0]      ld_data;
    logic                   alu_valid;
    logic                   alu_ready;
    logic [ADDR_W-1:0]      alu_dest;
    logic [DATA_W-1:0]      alu_data;
    logic                   reg_write_en;
    logic [ADDR_W-1:0]      reg_write_dest;
    logic [DATA_W-1:0]      reg_write_data;
    logic [ADDR_W-1:0]      fwd_addr_1;
    logic [ADDR_W-1:0]      fwd_addr_2;
    logic                   fwd_hit_1;
    logic                   fwd_hit_2;
    logic [DATA_W-1:0]      fwd_data_1;
    logic [DATA_W-1:0]      fwd_data_2;
    logic [2**ADDR_W-1:0]   pending;
    logic [CW-1:0]          wb_count;

    modport master (
        output ld_valid, ld_dest, ld_data, alu_valid, alu_dest, alu_data,
               fwd_addr_1, fwd_addr_2,
        input  ld_ready, alu_ready, reg_write_en, reg_write_dest, reg_write_data,
               fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2, pending, wb_count
    );

    modport slave (
        input  ld_valid, ld_dest, ld_data, alu_valid, alu_dest, alu_data,
               fwd_addr_1, fwd_addr_2,
        output ld_ready, alu_ready, reg_write_en, reg_write_dest, reg_write_data,
               fwd_hit_1, fwd_hit_2, fwd_data_1, fwd_data_2, pending, wb_count
    );
endinterface

// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - in-order writeback queue with register forwarding
module regfile_writeback #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 3,
    parameter int DEPTH  = 4
) (
    input logic              clk,
    input logic              rst,
    regfile_writeback_if.slave wb
);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int PW   = $clog2(DEPTH);
    localparam int NREG = 2**ADDR_W;

    logic [ADDR_W-1:0] q_dest_q [DEPTH];
    logic [ADDR_W-1:0] q_dest_d [DEPTH];
    logic [DATA_W-1:0] q_data_q [DEPTH];
    logic [DATA_W-1:0] q_data_d [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_dest_q, wr_dest_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;

    logic              ld_ready, alu_ready, push_ld, push_alu, pop;
    logic              hit_1, hit_2;
    logic [DATA_W-1:0] fdata_1, fdata_2;
    logic [NREG-1:0]   pend;
    logic [PW-1:0]     idx;

    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input int n);
        int s;
        s = int'(p) + n;
        if (s >= DEPTH) s = s - DEPTH;
        return PW'(s);
    endfunction

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
    always_comb begin
        ld_ready  = (count_q <= CW'(DEPTH - 1));
        alu_ready = wb.ld_valid ? (count_q <= CW'(DEPTH - 2)) : (count_q <= CW'(DEPTH - 1));
        push_ld   = wb.ld_valid & ld_ready;
        push_alu  = wb.alu_valid & alu_ready;
        pop       = (count_q != '0);
    end

    always_comb begin
        q_dest_d  = q_dest_q;
        q_data_d  = q_data_q;
        head_d    = head_q;
        tail_d    = tail_q;
        wr_en_d   = 1'b0;
        wr_dest_d = wr_dest_q;
        wr_data_d = wr_data_q;
        if (pop) begin
            wr_en_d   = 1'b1;
            wr_dest_d = q_dest_q[head_q];
            wr_data_d = q_data_q[head_q];
            head_d    = ptr_add(head_q, 1);
        end
        // Load goes in first so it retires ahead of a same-cycle ALU result.
        if (push_ld) begin
            q_dest_d[tail_d] = wb.ld_dest;
            q_data_d[tail_d] = wb.ld_data;
            tail_d           = ptr_add(tail_d, 1);
        end
        if (push_alu) begin
            q_dest_d[tail_d] = wb.alu_dest;
            q_data_d[tail_d] = wb.alu_data;
            tail_d           = ptr_add(tail_d, 1);
        end
        count_d = count_q + CW'(push_ld) + CW'(push_alu) - CW'(pop);
    end

    // Scan oldest to youngest so the last match left standing is the youngest write.
    always_comb begin
        hit_1   = 1'b0;
        hit_2   = 1'b0;
        fdata_1 = '0;
        fdata_2 = '0;
        pend    = '0;
        idx     = '0;
        if (wr_en_q) begin
            pend[wr_dest_q] = 1'b1;
            if (wr_dest_q == wb.fwd_addr_1) begin hit_1 = 1'b1; fdata_1 = wr_data_q; end
            if (wr_dest_q == wb.fwd_addr_2) begin hit_2 = 1'b1; fdata_2 = wr_data_q; end
        end
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count_q)) begin
                idx = ptr_add(head_q, i);
                pend[q_dest_q[idx]] = 1'b1;
                if (q_dest_q[idx] == wb.fwd_addr_1) begin hit_1 = 1'b1; fdata_1 = q_data_q[idx]; end
                if (q_dest_q[idx] == wb.fwd_addr_2) begin hit_2 = 1'b1; fdata_2 = q_data_q[idx]; end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_dest_q[i] <= '0;
                q_data_q[i] <= '0;
            end
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            wr_en_q   <= 1'b0;
            wr_dest_q <= '0;
            wr_data_q <= '0;
        end else begin
            q_dest_q  <= q_dest_d;
            q_data_q  <= q_data_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            wr_en_q   <= wr_en_d;
            wr_dest_q <= wr_dest_d;
            wr_data_q <= wr_data_d;
        end
    end

    assign wb.ld_ready       = ld_ready;
    assign wb.alu_ready      = alu_ready;
    assign wb.reg_write_en   = wr_en_q;
    assign wb.reg_write_dest = wr_dest_q;
    assign wb.reg_write_data = wr_data_q;
    assign wb.fwd_hit_1      = hit_1;
    assign wb.fwd_hit_2      = hit_2;
    assign wb.fwd_data_1     = fdata_1;
    assign wb.fwd_data_2     = fdata_2;
    assign wb.pending        = pend;
    assign wb.wb_count       = count_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// tb/tb_regfile_writeback.sv - scoreboard bench for regfile_writeback
module tb_regfile_writeback;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } ent_t;

    logic clk, rst;
    regfile_writeback_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) wb ();
    regfile_writeback #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .wb  (wb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    ent_t        mq[$];
    ent_t        exp_q[$];
    logic        infl_v;
    ent_t        infl;
    ent_t        last;
    logic [DATA_W-1:0] regs [2**ADDR_W];
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest accepted, not yet retired result.
    always @(negedge clk) begin
        if (rst === 1'b1 && wb.reg_write_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL spurious_write: got dest %0d data 0x%0h, expected no write",
                         wb.reg_write_dest, wb.reg_write_data);
            end else begin
                ent_t e;
                e = exp_q.pop_front();
                check("wr_dest", 32'(wb.reg_write_dest), 32'(e.dest));
                check("wr_data", 32'(wb.reg_write_data), 32'(e.data));
                regs[wb.reg_write_dest] = wb.reg_write_data;
            end
        end
    end

    function automatic void model_fwd(input logic [ADDR_W-1:0] a, output logic hit,
                                      output logic [DATA_W-1:0] d);
        hit = 1'b0;
        d   = '0;
        if (infl_v && infl.dest == a) begin hit = 1'b1; d = infl.data; end
        foreach (mq[i]) if (mq[i].dest == a) begin hit = 1'b1; d = mq[i].data; end
    endfunction

    // Called at a falling edge: drive, check combinational and registered outputs, advance model.
    task automatic cycle(input logic lv, input ent_t le, input logic av, input ent_t ae,
                         input logic [ADDR_W-1:0] f1, input logic [ADDR_W-1:0] f2,
                         output logic acc_l, output logic acc_a);
        logic exp_lr, exp_ar, h;
        logic [DATA_W-1:0] d;
        logic [2**ADDR_W-1:0] pend;
        int cnt;
        wb.ld_valid  = lv;  wb.ld_dest  = le.dest; wb.ld_data  = le.data;
        wb.alu_valid = av;  wb.alu_dest = ae.dest; wb.alu_data = ae.data;
        wb.fwd_addr_1 = f1; wb.fwd_addr_2 = f2;
        #1;
        cnt    = mq.size();
        exp_lr = (cnt <= DEPTH - 1);
        exp_ar = lv ? (cnt <= DEPTH - 2) : (cnt <= DEPTH - 1);
        check("ld_ready",  32'(wb.ld_ready),  32'(exp_lr));
        check("alu_ready", 32'(wb.alu_ready), 32'(exp_ar));
        check("wb_count",  32'(wb.wb_count),  32'(cnt));
        pend = '0;
        if (infl_v) pend[infl.dest] = 1'b1;
        foreach (mq[i]) pend[mq[i].dest] = 1'b1;
        check("pending", 32'(wb.pending), 32'(pend));
        model_fwd(f1, h, d);
        check("fwd_hit_1",  32'(wb.fwd_hit_1),  32'(h));
        check("fwd_data_1", 32'(wb.fwd_data_1), 32'(d));
        model_fwd(f2, h, d);
        check("fwd_hit_2",  32'(wb.fwd_hit_2),  32'(h));
        check("fwd_data_2", 32'(wb.fwd_data_2), 32'(d));
        check("reg_write_en",   32'(wb.reg_write_en),   32'(infl_v));
        check("reg_write_dest", 32'(wb.reg_write_dest), 32'(last.dest));
        check("reg_write_data", 32'(wb.reg_write_data), 32'(last.data));
        acc_l = lv && exp_lr;
        acc_a = av && exp_ar;
        if (mq.size() > 0) begin
            infl   = mq.pop_front();
            infl_v = 1'b1;
            last   = infl;
        end else begin
            infl_v = 1'b0;
        end
        if (acc_l) begin mq.push_back(le); exp_q.push_back(le); end
        if (acc_a) begin mq.push_back(ae); exp_q.push_back(ae); end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        logic al, aa;
        for (int i = 0; i < n; i++)
            cycle(1'b0, '0, 1'b0, '0, ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)), al, aa);
    endtask

    task automatic one(input logic lv, input ent_t le, input logic av, input ent_t ae,
                       input logic [ADDR_W-1:0] f1, input logic [ADDR_W-1:0] f2);
        logic al, aa;
        cycle(lv, le, av, ae, f1, f2, al, aa);
    endtask

    // Sources hold valid/dest/data until accepted.
    task automatic stream(input int nl, input int na, input int pct, input int bound);
        logic lv = 1'b0, av = 1'b0, al, aa;
        ent_t le = '0, ae = '0;
        int c = 0;
        while ((nl > 0 || na > 0 || lv || av) && c < bound) begin
            if (!lv && nl > 0 && $urandom_range(0, 99) < pct) begin
                lv = 1'b1; le.dest = ADDR_W'($urandom_range(0, 7)); le.data = DATA_W'($urandom); nl--;
            end
            if (!av && na > 0 && $urandom_range(0, 99) < pct) begin
                av = 1'b1; ae.dest = ADDR_W'($urandom_range(0, 7)); ae.data = DATA_W'($urandom); na--;
            end
            cycle(lv, le, av, ae, ADDR_W'($urandom_range(0, 7)), ADDR_W'($urandom_range(0, 7)), al, aa);
            if (al) lv = 1'b0;
            if (aa) av = 1'b0;
            c++;
        end
        if (nl > 0 || na > 0 || lv || av) begin
            n_vec++;
            n_err++;
            $display("FAIL stream_timeout: got %0d results still unsent after %0d cycles, expected 0",
                     nl + na + int'(lv) + int'(av), bound);
        end
    endtask

    initial begin
        rst = 1'b0;
        wb.ld_valid = 1'b0;  wb.ld_dest = '0;  wb.ld_data = '0;
        wb.alu_valid = 1'b0; wb.alu_dest = '0; wb.alu_data = '0;
        wb.fwd_addr_1 = '0;  wb.fwd_addr_2 = '0;
        infl_v = 1'b0; infl = '0; last = '0;
        foreach (regs[i]) regs[i] = '0;
        repeat (2) @(negedge clk);
        check("rst_write_en",   32'(wb.reg_write_en),   32'd0);
        check("rst_write_dest", 32'(wb.reg_write_dest), 32'd0);
        check("rst_write_data", 32'(wb.reg_write_data), 32'd0);
        check("rst_count",      32'(wb.wb_count),       32'd0);
        check("rst_pending",    32'(wb.pending),        32'd0);
        rst = 1'b1;
        idle(2);

        one(1'b0, '0, 1'b1, '{dest: 3'd3, data: 16'h1234}, 3'd3, 3'd0);
        idle(4);
        check("t1_r3", 32'(regs[3]), 32'h1234);

        one(1'b1, '{dest: 3'd1, data: 16'hAAAA}, 1'b1, '{dest: 3'd2, data: 16'h5555}, 3'd1, 3'd2);
        idle(4);
        check("t2_r1", 32'(regs[1]), 32'hAAAA);
        check("t2_r2", 32'(regs[2]), 32'h5555);

        stream(3, 3, 100, 30);
        idle(DEPTH + 2);

        one(1'b1, '{dest: 3'd5, data: 16'h0F0F}, 1'b1, '{dest: 3'd5, data: 16'hBEEF}, 3'd5, 3'd6);
        one(1'b0, '0, 1'b0, '0, 3'd5, 3'd6);
        idle(4);
        check("t4_r5", 32'(regs[5]), 32'hBEEF);

        one(1'b1, '{dest: 3'd1, data: 16'h1111}, 1'b1, '{dest: 3'd2, data: 16'h2222}, 3'd1, 3'd2);
        one(1'b1, '{dest: 3'd3, data: 16'h3333}, 1'b1, '{dest: 3'd4, data: 16'h4444}, 3'd3, 3'd4);
        wb.ld_valid = 1'b0;
        wb.alu_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("t5_write_en", 32'(wb.reg_write_en), 32'd0);
        check("t5_count",    32'(wb.wb_count),     32'd0);
        check("t5_pending",  32'(wb.pending),      32'd0);
        mq.delete();
        exp_q.delete();
        infl_v = 1'b0;
        last = '0;
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        idle(5);

        stream(150, 150, 60, 2000);
        stream(100, 100, 95, 2000);
        idle(DEPTH + 3);
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
